med3x3_core: RTL and testbench
==============================

MED3X3_CORE -- requirements
Module: med3x3_core

Interface
REQ-001 C_DATA_WIDTH, 8, pixel width in bits.
REQ-002 C_LINE_WIDTH, 640, pixels per image line; legal range 3..65535.
REQ-003 clk  input  1  single clock; all logic rising-edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 en  input  1  column-fetch enable; low stalls fetching, pipeline keeps draining.
REQ-006 row0_dout, row1_dout, row2_dout  input  C_DATA_WIDTH each  FIFO head data (row0 oldest line, row2 newest); valid whenever the matching empty is low.
REQ-007 row0_empty, row1_empty, row2_empty  input  1 each  FIFO empty flags.
REQ-008 rd_en  output  1  common read strobe to all three upstream FIFOs.
REQ-009 out_valid  output  1  one-cycle strobe qualifying out_data.
REQ-010 out_data  output  C_DATA_WIDTH  3x3 median.
REQ-011 state  output  2  FSM state: 0 IDLE, 1 FILL, 2 RUN.

Function
REQ-012 rd_en SHALL be combinational: en & ~row0_empty & ~row1_empty & ~row2_empty; a cycle with rd_en high is a "fetch".
REQ-013 On each fetch the three head pixels SHALL form one column, shifted into a 3-column window register at the next edge (oldest column dropped).
REQ-014 Column counter col (16 bit) SHALL increment per fetch and wrap from C_LINE_WIDTH-1 to 0; no change without fetch.
REQ-015 A window SHALL be valid when the fetched column has col >= 2; columns 0 and 1 of every line produce no output (output C_LINE_WIDTH-2 pixels per line, no window straddles a line).
REQ-016 FSM: IDLE->FILL on en; FILL->RUN on fetch with col==1; RUN->FILL on fetch with col==C_LINE_WIDTH-1; FILL/RUN->IDLE when en low and col==0; en low with col!=0 holds state.
REQ-017 Median pipeline: stage1 sorts each column (min/mid/max); stage2 computes max of mins, median of mids, min of maxes; stage3 computes median of those three.
REQ-018 Latency: out_valid SHALL assert exactly 4 clocks after the fetch cycle of the completing column; back-to-back fetches give back-to-back outputs, throughput 1 pixel/clock.
REQ-019 Comparisons unsigned; equal values resolve to either operand (value-identical); no width growth.
REQ-020 Stalls (empty or en low) SHALL insert bubbles only; window and col hold, no output duplicated or lost.
REQ-021 out_data SHALL hold its last value while out_valid is low.

Reset
REQ-022 On rst: window, pipeline data, out_data = 0; pipeline valid bits, out_valid = 0; col = 0; state = IDLE; effective immediately regardless of clock.
REQ-023 rst asserted mid-line SHALL discard all in-flight windows; first output after release requires 3 new fetches starting at col 0.
REQ-024 rd_en SHALL be 0 while rst is high.

Configuration
REQ-025 Macro MED_LINE_CNT_EN: when defined, adds output out_last (1, high with the out_valid of the last pixel of each line, col C_LINE_WIDTH-1) and output line_count (16, completed lines, increments with out_last, wraps at 65535->0, reset 0), both pipelined to align with out_data.
REQ-026 Without MED_LINE_CNT_EN those ports and logic SHALL not exist; all other behaviour identical.

Verification
REQ-027 C_LINE_WIDTH=8, all FIFOs hold 8 pixels of 10, en=1 -> 8 rd_en cycles, 6 outputs of 10, first out_valid 4 clocks after third fetch.
REQ-028 Rows 0..7, 10..17, 20..27 per column sequence, width 8 -> outputs 11,12,13,14,15,16.
REQ-029 Window columns {9,1,5},{3,7,2},{8,4,6} -> out_data 5; all-equal 0xFF window -> 0xFF.
REQ-030 row1_empty pulsed high 3 cycles mid-line -> rd_en low those cycles, outputs delayed 3 clocks, values unchanged, count still 6.
REQ-031 rst pulsed (async, between edges) after 5 fetches -> outputs, state, col clear immediately; next line yields full 6 outputs.
REQ-032 With MED_LINE_CNT_EN, 3 lines of width 8 -> out_last on 6th, 12th, 18th output; line_count 1,2,3.

Source files
------------

// File: rtl/med3x3_core.sv
// rtl/med3x3_core.sv - 3x3 median filter core fed by three line FIFOs; optional MED_LINE_CNT_EN adds out_last/line_count
module med3x3_core #(
    parameter int C_DATA_WIDTH = 8,
    parameter int C_LINE_WIDTH = 640
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic [C_DATA_WIDTH-1:0] row0_dout,
    input  logic [C_DATA_WIDTH-1:0] row1_dout,
    input  logic [C_DATA_WIDTH-1:0] row2_dout,
    input  logic                    row0_empty,
    input  logic                    row1_empty,
    input  logic                    row2_empty,
    output logic                    rd_en,
    output logic                    out_valid,
    output logic [C_DATA_WIDTH-1:0] out_data,
    output logic [1:0]              state
`ifdef MED_LINE_CNT_EN
    ,
    output logic                    out_last,
    output logic [15:0]             line_count
`endif
);

    localparam int DW = C_DATA_WIDTH;
    localparam logic [15:0] C_LAST_COL = 16'(C_LINE_WIDTH - 1);

    typedef logic [DW-1:0] pix_t;
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_FILL = 2'd1,
        S_RUN  = 2'd2
    } state_t;

    function automatic pix_t min2(input pix_t a, input pix_t b);
        return (a < b) ? a : b;
    endfunction

    function automatic pix_t max2(input pix_t a, input pix_t b);
        return (a < b) ? b : a;
    endfunction

    function automatic pix_t med3(input pix_t a, input pix_t b, input pix_t c);
        return max2(min2(a, b), min2(max2(a, b), c));
    endfunction

    logic                   fetch;
    logic [15:0]            col_q, col_d;
    logic [2:0][2:0][DW-1:0] win_q;          // [column 0 oldest][row]
    logic [2:0][2:0][DW-1:0] s1_q, s1_d;     // [column][0 min, 1 mid, 2 max]
    logic [2:0][DW-1:0]     s2_q, s2_d;      // 0 max of mins, 1 median of mids, 2 min of maxes
    pix_t                   out_data_q, out_data_d;
    logic                   v0_q, v1_q, v2_q, out_valid_q;
    state_t                 state_q;

    // Common read strobe; a high cycle is one column fetch
    assign rd_en = en & ~rst & ~row0_empty & ~row1_empty & ~row2_empty;
    assign fetch = rd_en;

    // Column position of the next fetched column, wrapping at line end
    always_comb begin
        col_d = col_q;
        if (fetch) begin
            col_d = (col_q == C_LAST_COL) ? 16'd0 : col_q + 16'd1;
        end
    end

    // Median network: per-column sort, cross-column reduce, final median
    always_comb begin
        s1_d = '0;
        for (int c = 0; c < 3; c++) begin
            s1_d[c][0] = min2(min2(win_q[c][0], win_q[c][1]), win_q[c][2]);
            s1_d[c][1] = med3(win_q[c][0], win_q[c][1], win_q[c][2]);
            s1_d[c][2] = max2(max2(win_q[c][0], win_q[c][1]), win_q[c][2]);
        end
        s2_d[0]    = max2(max2(s1_q[0][0], s1_q[1][0]), s1_q[2][0]);
        s2_d[1]    = med3(s1_q[0][1], s1_q[1][1], s1_q[2][1]);
        s2_d[2]    = min2(min2(s1_q[0][2], s1_q[1][2]), s1_q[2][2]);
        out_data_d = med3(s2_q[0], s2_q[1], s2_q[2]);
    end

    // Window shift on fetch and the three-stage valid/data pipeline
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col_q       <= '0;
            win_q       <= '0;
            s1_q        <= '0;
            s2_q        <= '0;
            out_data_q  <= '0;
            v0_q        <= 1'b0;
            v1_q        <= 1'b0;
            v2_q        <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            col_q <= col_d;
            if (fetch) begin
                win_q[0] <= win_q[1];
                win_q[1] <= win_q[2];
                win_q[2] <= {row2_dout, row1_dout, row0_dout};
            end
            // Columns 0 and 1 only prime the window; no window straddles a line
            v0_q        <= fetch && (col_q >= 16'd2);
            v1_q        <= v0_q;
            v2_q        <= v1_q;
            out_valid_q <= v2_q;
            if (v0_q) s1_q <= s1_d;
            if (v1_q) s2_q <= s2_d;
            if (v2_q) out_data_q <= out_data_d;
        end
    end

    // Line-phase FSM: FILL while priming a line, RUN while windows are valid
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: if (en) state_q <= S_FILL;
                S_FILL: begin
                    if (fetch && col_q == 16'd1)  state_q <= S_RUN;
                    else if (!en && col_q == 16'd0) state_q <= S_IDLE;
                end
                S_RUN: begin
                    if (fetch && col_q == C_LAST_COL) state_q <= S_FILL;
                    else if (!en && col_q == 16'd0)  state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign state     = state_q;

`ifdef MED_LINE_CNT_EN
    logic        last0_q, last1_q, last2_q, out_last_q;
    logic [15:0] line_count_q;

    // End-of-line marker travels alongside the window valid bit
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last0_q      <= 1'b0;
            last1_q      <= 1'b0;
            last2_q      <= 1'b0;
            out_last_q   <= 1'b0;
            line_count_q <= '0;
        end else begin
            last0_q    <= fetch && (col_q == C_LAST_COL);
            last1_q    <= last0_q;
            last2_q    <= last1_q;
            out_last_q <= v2_q && last2_q;
            if (v2_q && last2_q) line_count_q <= line_count_q + 16'd1;
        end
    end

    assign out_last   = out_last_q;
    assign line_count = line_count_q;
`endif

endmodule

// File: tb/tb_med3x3_core.sv
// tb/tb_med3x3_core.sv - directed self-checking bench for med3x3_core with line width 8
module tb_med3x3_core;

    localparam int DW = 8;
    localparam int LW = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          en = 1'b0;
    logic [DW-1:0] row0_dout = '0, row1_dout = '0, row2_dout = '0;
    logic          row0_empty = 1'b1, row1_empty = 1'b1, row2_empty = 1'b1;
    logic          rd_en, out_valid;
    logic [DW-1:0] out_data;
    logic [1:0]    state;
`ifdef MED_LINE_CNT_EN
    logic          out_last;
    logic [15:0]   line_count;
    logic          last_q[$];
    logic [15:0]   lc_q[$];
`endif

    med3x3_core #(.C_DATA_WIDTH(DW), .C_LINE_WIDTH(LW)) dut (
        .clk(clk), .rst(rst), .en(en),
        .row0_dout(row0_dout), .row1_dout(row1_dout), .row2_dout(row2_dout),
        .row0_empty(row0_empty), .row1_empty(row1_empty), .row2_empty(row2_empty),
        .rd_en(rd_en), .out_valid(out_valid), .out_data(out_data), .state(state)
`ifdef MED_LINE_CNT_EN
        , .out_last(out_last), .line_count(line_count)
`endif
    );

    always #5 clk = ~clk;

    int            cyc = 0;
    int            passed = 0;
    int            total = 0;
    logic [DW-1:0] q0[$], q1[$], q2[$];
    bit            force1 = 1'b0;
    int            fetch_cyc[$];
    logic [DW-1:0] out_q[$];
    int            out_cyc[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic refresh();
        row0_dout  = (q0.size() > 0) ? q0[0] : '0;
        row1_dout  = (q1.size() > 0) ? q1[0] : '0;
        row2_dout  = (q2.size() > 0) ? q2[0] : '0;
        row0_empty = (q0.size() == 0);
        row1_empty = (q1.size() == 0) || force1;
        row2_empty = (q2.size() == 0);
    endtask

    // FIFO model: pop after the edge that consumed the head
    always @(posedge clk) begin : fifo_model
        logic pop;
        pop = rd_en;
        #1;
        if (pop && q0.size() > 0 && q1.size() > 0 && q2.size() > 0) begin
            void'(q0.pop_front());
            void'(q1.pop_front());
            void'(q2.pop_front());
        end
        refresh();
    end

    // Monitor on the falling edge
    always @(negedge clk) begin
        if (rd_en) fetch_cyc.push_back(cyc);
        if (out_valid) begin
            out_q.push_back(out_data);
            out_cyc.push_back(cyc);
`ifdef MED_LINE_CNT_EN
            last_q.push_back(out_last);
            lc_q.push_back(line_count);
`endif
        end
    end

    task automatic clear_mon();
        fetch_cyc.delete();
        out_q.delete();
        out_cyc.delete();
`ifdef MED_LINE_CNT_EN
        last_q.delete();
        lc_q.delete();
`endif
    endtask

    task automatic load_ramp(input int lines);
        for (int l = 0; l < lines; l++) begin
            for (int i = 0; i < LW; i++) begin
                q0.push_back(8'(i));
                q1.push_back(8'(i + 10));
                q2.push_back(8'(i + 20));
            end
        end
        refresh();
    endtask

    task automatic wait_outputs(input int n, input int budget, output bit ok);
        int k;
        k = 0;
        while (out_q.size() < n && k < budget) begin
            @(negedge clk);
            #1;
            k++;
        end
        repeat (8) @(negedge clk);
        #1;
        ok = (out_q.size() >= n);
    endtask

    task automatic test_reset();
        bit hit;
        en = 1'b1;
        q0.push_back(8'd1); q1.push_back(8'd2); q2.push_back(8'd3);
        refresh();
        #1;
        total++; if (rd_en !== 1'b0) $display("FAIL reset_rd_en: got %b want 0", rd_en); else passed++;
        total++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", out_valid); else passed++;
        total++; if (out_data !== 8'd0) $display("FAIL reset_out_data: got %0d want 0", out_data); else passed++;
        total++; if (state !== 2'd0) $display("FAIL reset_state: got %0d want 0", state); else passed++;
        hit = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (rd_en !== 1'b0) hit = 1'b1;
        end
        total++; if (hit) $display("FAIL reset_rd_en_held: got 1 want 0"); else passed++;
        q0.delete(); q1.delete(); q2.delete();
        en = 1'b0;
        refresh();
        @(posedge clk); #2 rst = 1'b0;
    endtask

    task automatic test_basic();
        bit ok;
        int k;
        clear_mon();
        @(posedge clk); #2;
        load_ramp(1);
        en = 1'b1;
        k = 0;
        while (fetch_cyc.size() < 3 && k < 50) begin @(negedge clk); #1; k++; end
        total++; if (state !== 2'd2) $display("FAIL basic_state_run: got %0d want 2", state); else passed++;
        wait_outputs(6, 100, ok);
        total++; if (!ok) $display("FAIL basic_timeout: got %0d outputs want 6", out_q.size()); else passed++;
        total++; if (out_q.size() != 6) $display("FAIL basic_count: got %0d want 6", out_q.size()); else passed++;
        total++; if (fetch_cyc.size() != 8) $display("FAIL basic_fetches: got %0d want 8", fetch_cyc.size()); else passed++;
        for (int i = 0; i < 6; i++) begin
            total++;
            if (out_q.size() <= i || out_q[i] !== 8'(11 + i))
                $display("FAIL basic_data[%0d]: got %0d want %0d", i, (out_q.size() > i) ? out_q[i] : 8'hxx, 11 + i);
            else passed++;
        end
        if (out_q.size() >= 6 && fetch_cyc.size() >= 3) begin
            total++; if (out_cyc[0] - fetch_cyc[2] != 4) $display("FAIL basic_latency: got %0d want 4", out_cyc[0] - fetch_cyc[2]); else passed++;
            total++; if (out_cyc[5] - out_cyc[0] != 5) $display("FAIL basic_throughput: got %0d want 5", out_cyc[5] - out_cyc[0]); else passed++;
        end
        total++; if (state !== 2'd1) $display("FAIL basic_state_fill: got %0d want 1", state); else passed++;
        total++; if (out_valid !== 1'b0 || out_data !== 8'd16) $display("FAIL basic_hold: got v=%b d=%0d want v=0 d=16", out_valid, out_data); else passed++;
        @(posedge clk); #2 en = 1'b0;
        @(posedge clk); #2;
        total++; if (state !== 2'd0) $display("FAIL basic_state_idle: got %0d want 0", state); else passed++;
    endtask

    task automatic test_window_values();
        bit ok;
        logic [DW-1:0] a0[LW], a1[LW], a2[LW], exp_v[6];
        a0 = '{8'd9, 8'd3, 8'd8, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
        a1 = '{8'd1, 8'd7, 8'd4, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
        a2 = '{8'd5, 8'd2, 8'd6, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
        exp_v = '{8'd5, 8'd7, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
        clear_mon();
        @(posedge clk); #2;
        for (int i = 0; i < LW; i++) begin
            q0.push_back(a0[i]); q1.push_back(a1[i]); q2.push_back(a2[i]);
        end
        refresh();
        en = 1'b1;
        wait_outputs(6, 100, ok);
        total++; if (out_q.size() != 6) $display("FAIL window_count: got %0d want 6", out_q.size()); else passed++;
        for (int i = 0; i < 6; i++) begin
            total++;
            if (out_q.size() <= i || out_q[i] !== exp_v[i])
                $display("FAIL window_data[%0d]: got %0h want %0h", i, (out_q.size() > i) ? out_q[i] : 8'hxx, exp_v[i]);
            else passed++;
        end
        @(posedge clk); #2 en = 1'b0;
    endtask

    task automatic test_stall();
        bit ok;
        int k;
        clear_mon();
        @(posedge clk); #2;
        load_ramp(1);
        en = 1'b1;
        k = 0;
        while (fetch_cyc.size() < 4 && k < 50) begin @(negedge clk); #1; k++; end
        @(posedge clk); #2;
        force1 = 1'b1;
        refresh();
        for (int i = 0; i < 3; i++) begin
            #1;
            total++; if (rd_en !== 1'b0) $display("FAIL stall_rd_en[%0d]: got %b want 0", i, rd_en); else passed++;
            @(posedge clk);
        end
        #2 force1 = 1'b0;
        refresh();
        wait_outputs(6, 100, ok);
        total++; if (out_q.size() != 6) $display("FAIL stall_count: got %0d want 6", out_q.size()); else passed++;
        total++; if (fetch_cyc.size() != 8) $display("FAIL stall_fetches: got %0d want 8", fetch_cyc.size()); else passed++;
        for (int i = 0; i < 6; i++) begin
            total++;
            if (out_q.size() <= i || out_q[i] !== 8'(11 + i))
                $display("FAIL stall_data[%0d]: got %0d want %0d", i, (out_q.size() > i) ? out_q[i] : 8'hxx, 11 + i);
            else passed++;
        end
        if (out_q.size() >= 6 && fetch_cyc.size() >= 1) begin
            total++; if (out_cyc[5] - fetch_cyc[0] != 14) $display("FAIL stall_span: got %0d want 14", out_cyc[5] - fetch_cyc[0]); else passed++;
        end
        @(posedge clk); #2 en = 1'b0;
    endtask

    task automatic test_reset_midline();
        bit ok;
        int k;
        clear_mon();
        @(posedge clk); #2;
        load_ramp(1);
        en = 1'b1;
        k = 0;
        while (fetch_cyc.size() < 5 && k < 50) begin @(negedge clk); #1; k++; end
        @(posedge clk); #2;
        rst = 1'b1;
        q0.delete(); q1.delete(); q2.delete();
        refresh();
        #1;
        total++; if (out_data !== 8'd0) $display("FAIL rstmid_out_data: got %0d want 0", out_data); else passed++;
        total++; if (out_valid !== 1'b0) $display("FAIL rstmid_out_valid: got %b want 0", out_valid); else passed++;
        total++; if (state !== 2'd0) $display("FAIL rstmid_state: got %0d want 0", state); else passed++;
        @(posedge clk); @(posedge clk); #2 rst = 1'b0;
        clear_mon();
        repeat (8) @(negedge clk);
        #1;
        total++; if (out_q.size() != 0) $display("FAIL rstmid_flushed: got %0d outputs want 0", out_q.size()); else passed++;
        @(posedge clk); #2;
        load_ramp(1);
        wait_outputs(6, 100, ok);
        total++; if (out_q.size() != 6) $display("FAIL rstmid_count: got %0d want 6", out_q.size()); else passed++;
        for (int i = 0; i < 6; i++) begin
            total++;
            if (out_q.size() <= i || out_q[i] !== 8'(11 + i))
                $display("FAIL rstmid_data[%0d]: got %0d want %0d", i, (out_q.size() > i) ? out_q[i] : 8'hxx, 11 + i);
            else passed++;
        end
        if (out_q.size() >= 1 && fetch_cyc.size() >= 3) begin
            total++; if (out_cyc[0] - fetch_cyc[2] != 4) $display("FAIL rstmid_latency: got %0d want 4", out_cyc[0] - fetch_cyc[2]); else passed++;
        end
        @(posedge clk); #2 en = 1'b0;
    endtask

`ifdef MED_LINE_CNT_EN
    task automatic test_line_count();
        bit ok;
        @(posedge clk); #2 rst = 1'b1;
        @(posedge clk); #2 rst = 1'b0;
        clear_mon();
        load_ramp(3);
        en = 1'b1;
        wait_outputs(18, 200, ok);
        total++; if (out_q.size() != 18) $display("FAIL lc_count: got %0d want 18", out_q.size()); else passed++;
        for (int i = 0; i < 18; i++) begin
            total++;
            if (last_q.size() <= i || last_q[i] !== ((i % 6) == 5))
                $display("FAIL lc_last[%0d]: got %b want %b", i, (last_q.size() > i) ? last_q[i] : 1'bx, (i % 6) == 5);
            else passed++;
            if ((i % 6) == 5) begin
                total++;
                if (lc_q.size() <= i || lc_q[i] !== 16'(i / 6 + 1))
                    $display("FAIL lc_value[%0d]: got %0d want %0d", i, (lc_q.size() > i) ? lc_q[i] : 16'hxxxx, i / 6 + 1);
                else passed++;
            end
        end
        @(posedge clk); #2 en = 1'b0;
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        refresh();
        test_reset();
        test_basic();
        test_window_values();
        test_stall();
        test_reset_midline();
`ifdef MED_LINE_CNT_EN
        test_line_count();
`endif
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
